// File: rtl/bist_pkg.sv
// Shared types, the March C- element table and the checkerboard pattern for the memory BIST.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    typedef enum logic {MARCH_CM, CHECKER} mode_e;

    // One March element: address direction (1 = ascending), optional read and optional write.
    typedef struct packed {
        logic dir;
        logic has_read;
        logic read_val;
        logic has_write;
        logic write_val;
    } march_elem_t;

    localparam int unsigned NUM_MARCH_ELEMS    = 6;
    localparam int unsigned NUM_CHECKER_PASSES = 4;

    localparam march_elem_t MARCH_TABLE [NUM_MARCH_ELEMS] = '{
        '{dir: 1'b1, has_read: 1'b0, read_val: 1'b0, has_write: 1'b1, write_val: 1'b0},
        '{dir: 1'b1, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1},
        '{dir: 1'b1, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0},
        '{dir: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1},
        '{dir: 1'b0, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0},
        '{dir: 1'b1, has_read: 1'b1, read_val: 1'b0, has_write: 1'b0, write_val: 1'b0}
    };

    // Bit bit_idx of the checkerboard word: 0x55.. on even addresses, 0xAA.. on odd ones.
    function automatic logic checker_pattern_bit(input int unsigned bit_idx, input logic addr_lsb);
        return (bit_idx % 2 == 0) ? ~addr_lsb : addr_lsb;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down address counter with synchronous load and a direction-aware terminal-count flag.
module bist_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  tc
);

    // Load has priority over stepping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (en) begin
            addr <= up ? addr + 1'b1 : addr - 1'b1;
        end
    end

    assign tc = up ? &addr : ~|addr;

endmodule

// File: rtl/mem_march_bist.sv
// March C- / checkerboard BIST controller driving a dual-port memory from one clock.
module mem_march_bist
    import bist_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ERR_WIDTH  = 8
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  bist_en,
    input  logic                  mode,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  passfail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ERR_WIDTH-1:0]  err_cnt
);

    localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = ADDR_WIDTH'(DEPTH - 1);

    state_e                state;
    mode_e                 mode_q;
    logic [2:0]            elem;
    logic                  phase;
    logic                  issue_done;
    logic [DATA_WIDTH-1:0] exp_word;
    logic                  cmp_valid;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic                  fail_flag;

    march_elem_t           cur_desc;
    march_elem_t           nxt_desc;
    logic [2:0]            elem_nxt;
    logic                  op_read;
    logic                  op_write;
    logic [DATA_WIDTH-1:0] op_data;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  pair_split;
    logic                  last_elem;
    logic                  cur_up;
    logic                  next_up;
    logic                  start;
    logic                  issuing;
    logic                  gen_load;
    logic                  gen_en;
    logic [ADDR_WIDTH-1:0] gen_load_val;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  tc;
    logic                  mismatch;

    // Decode the operation for the current element, phase and address.
    always_comb begin
        cur_desc   = MARCH_TABLE[elem];
        nxt_desc   = cur_desc;
        elem_nxt   = elem + 3'd1;
        op_read    = 1'b0;
        op_write   = 1'b0;
        op_data    = '0;
        pair_split = 1'b0;
        last_elem  = 1'b0;
        cur_up     = 1'b1;
        next_up    = 1'b1;
        pattern    = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            pattern[b] = checker_pattern_bit(b, addr[0]);
        end
        if (mode_q == MARCH_CM) begin
            last_elem  = (elem == 3'(NUM_MARCH_ELEMS - 1));
            nxt_desc   = MARCH_TABLE[last_elem ? elem : elem_nxt];
            op_read    = cur_desc.has_read && !phase;
            op_write   = !op_read;
            op_data    = op_read ? {DATA_WIDTH{cur_desc.read_val}}
                                 : {DATA_WIDTH{cur_desc.write_val}};
            // A read that is followed by a write at the same address holds the counter.
            pair_split = op_read && cur_desc.has_write;
            cur_up     = cur_desc.dir;
            next_up    = nxt_desc.dir;
        end else begin
            last_elem = (elem == 3'(NUM_CHECKER_PASSES - 1));
            op_read   = elem[0];
            op_write  = !elem[0];
            op_data   = elem[1] ? ~pattern : pattern;
        end
    end

    assign start        = (state == IDLE) && bist_en;
    assign issuing      = (state == RUN) && bist_en && !issue_done;
    assign gen_load     = start || (issuing && !pair_split && tc && !last_elem);
    assign gen_en       = issuing && !pair_split && !tc;
    assign gen_load_val = (start || next_up) ? '0 : ADDR_TOP;
    assign mismatch     = cmp_valid && (mem_rdata != cmp_exp);

    bist_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (wclk),
        .rst     (rst),
        .load    (gen_load),
        .load_val(gen_load_val),
        .en      (gen_en),
        .up      (cur_up),
        .addr    (addr),
        .tc      (tc)
    );

    // Control FSM, memory port registers, compare pipeline and result registers.
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= MARCH_CM;
            elem       <= '0;
            phase      <= 1'b0;
            issue_done <= 1'b0;
            exp_word   <= '0;
            cmp_valid  <= 1'b0;
            cmp_exp    <= '0;
            cmp_addr   <= '0;
            fail_flag  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_ren    <= 1'b0;
            mem_raddr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            passfail   <= 1'b0;
            fail_addr  <= '0;
            err_cnt    <= '0;
        end else begin
            mem_wen   <= 1'b0;
            mem_ren   <= 1'b0;
            // Expected word and address ride one stage behind the read enable.
            cmp_valid <= mem_ren;
            cmp_exp   <= exp_word;
            cmp_addr  <= mem_raddr;

            if ((state == RUN || state == DRAIN) && mismatch) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                fail_flag <= 1'b1;
                if (!fail_flag) begin
                    fail_addr <= cmp_addr;
                end
            end

            unique case (state)
                IDLE: begin
                    if (bist_en) begin
                        state      <= RUN;
                        mode_q     <= mode_e'(mode);
                        elem       <= '0;
                        phase      <= 1'b0;
                        issue_done <= 1'b0;
                        fail_flag  <= 1'b0;
                        fail_addr  <= '0;
                        err_cnt    <= '0;
                        passfail   <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (!bist_en) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        fail_flag <= 1'b0;
                        fail_addr <= '0;
                        err_cnt   <= '0;
                        passfail  <= 1'b0;
                    end else if (state == DRAIN) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        passfail <= ~(fail_flag | mismatch);
                    end else if (issue_done) begin
                        state <= DRAIN;
                    end else begin
                        mem_wen   <= op_write;
                        mem_ren   <= op_read;
                        mem_waddr <= addr;
                        mem_raddr <= addr;
                        mem_wdata <= op_data;
                        exp_word  <= op_data;
                        if (pair_split) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (tc) begin
                                if (last_elem) begin
                                    issue_done <= 1'b1;
                                end else begin
                                    elem <= elem_nxt;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (!bist_en) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_march_bist.sv
// Scoreboard bench for mem_march_bist with a behavioural 16x8 memory and an optional stuck-at fault.
module tb_mem_march_bist;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int EW = 8;

    logic          wclk = 1'b0;
    logic          rst = 1'b0;
    logic          bist_en = 1'b0;
    logic          mode = 1'b0;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          done;
    logic          passfail;
    logic [AW-1:0] fail_addr;
    logic [EW-1:0] err_cnt;

    logic [DW-1:0] mem_arr [16];
    logic          fault = 1'b0;

    always #5 wclk = ~wclk;

    mem_march_bist #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ERR_WIDTH (EW)
    ) dut (
        .wclk     (wclk),
        .rst      (rst),
        .bist_en  (bist_en),
        .mode     (mode),
        .mem_wen  (mem_wen),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_ren  (mem_ren),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .done     (done),
        .passfail (passfail),
        .fail_addr(fail_addr),
        .err_cnt  (err_cnt)
    );

    // Memory model; the fault forces bit 3 high on reads of address 5.
    always @(posedge wclk) begin
        if (mem_wen) mem_arr[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem_arr[mem_raddr] | ((fault && mem_raddr == 4'd5) ? 8'h08 : 8'h00);
    end

    typedef struct {
        string name;
        int    latency;
        int    ops;
        int    pass;
        int    errs;
        int    faddr;
        int    wr5_n;
        int    wr5_a;
        int    wr5_b;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    function automatic void chk(string nm, int act, int exp_v);
        compared++;
        if (act != exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endfunction

    // Monitor: tracks each run from the rise of busy and scores it when done rises.
    int           n = 0, n0 = 0, ops = 0, both = 0, wr5_n = 0, first_addr = -1, first_wr = -1;
    logic [7:0]   wr5 [4];
    logic         busy_p = 1'b0, done_p = 1'b0, first_seen = 1'b0;
    exp_t         e;

    always @(negedge wclk) begin
        n++;
        if (busy && !busy_p) begin
            n0 = n; ops = 0; both = 0; wr5_n = 0; first_seen = 1'b0;
            first_addr = -1; first_wr = -1;
            for (int i = 0; i < 4; i++) wr5[i] = 8'hEE;
        end
        if (busy) begin
            if (mem_wen || mem_ren) begin
                ops++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_addr = mem_wen ? int'(mem_waddr) : int'(mem_raddr);
                    first_wr   = int'(mem_wen);
                end
            end
            if (mem_wen && mem_ren) both++;
            if (mem_wen && mem_waddr == 4'd5) begin
                if (wr5_n < 4) wr5[wr5_n] = mem_wdata;
                wr5_n++;
            end
        end
        if (done && !done_p) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_latency"}, n - n0, e.latency);
                chk({e.name, "_ops"}, ops, e.ops);
                chk({e.name, "_both_en"}, both, 0);
                chk({e.name, "_busy_at_done"}, int'(busy), 0);
                chk({e.name, "_passfail"}, int'(passfail), e.pass);
                chk({e.name, "_err_cnt"}, int'(err_cnt), e.errs);
                chk({e.name, "_fail_addr"}, int'(fail_addr), e.faddr);
                chk({e.name, "_first_addr"}, first_addr, 0);
                chk({e.name, "_first_is_write"}, first_wr, 1);
                chk({e.name, "_wr5_count"}, wr5_n, e.wr5_n);
                chk({e.name, "_wr5_first"}, int'(wr5[0]), e.wr5_a);
                chk({e.name, "_wr5_second"}, int'(wr5[1]), e.wr5_b);
            end
        end
        busy_p = busy;
        done_p = done;
    end

    task automatic wait_done(string nm);
        for (int i = 0; i < 400; i++) begin
            @(negedge wclk);
            if (done) break;
        end
        chk({nm, "_done_seen"}, int'(done), 1);
    endtask

    // Hold results in DONE, release BIST_EN and confirm they stay in IDLE.
    task automatic finish_run(string nm, int pass, int errs);
        repeat (2) @(negedge wclk);
        chk({nm, "_done_held"}, int'(done), 1);
        chk({nm, "_pass_held"}, int'(passfail), pass);
        bist_en = 1'b0;
        @(negedge wclk);
        chk({nm, "_done_idle"}, int'(done), 0);
        chk({nm, "_pass_idle"}, int'(passfail), pass);
        chk({nm, "_errs_idle"}, int'(err_cnt), errs);
        @(negedge wclk);
    endtask

    task automatic full_run(string nm, logic m, logic f, int lat, int nops, int pass, int errs,
                            int faddr, int w5n, int w5a, int w5b);
        exp_t x;
        x = '{nm, lat, nops, pass, errs, faddr, w5n, w5a, w5b};
        sb.push_back(x);
        fault   = f;
        mode    = m;
        bist_en = 1'b1;
        wait_done(nm);
        finish_run(nm, pass, errs);
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_passfail"}, int'(passfail), 0);
        chk({nm, "_err_cnt"}, int'(err_cnt), 0);
        chk({nm, "_fail_addr"}, int'(fail_addr), 0);
        chk({nm, "_enables"}, int'(mem_wen) + int'(mem_ren), 0);
    endtask

    initial begin
        int en_seen;
        exp_t x;
        repeat (3) @(negedge wclk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge wclk);

        full_run("march_ok", 1'b0, 1'b0, 162, 160, 1, 0, 0, 5, 8'h00, 8'hFF);
        full_run("march_sa1", 1'b0, 1'b1, 162, 160, 0, 3, 5, 5, 8'h00, 8'hFF);
        full_run("chk_ok", 1'b1, 1'b0, 66, 64, 1, 0, 0, 2, 8'hAA, 8'h55);
        full_run("chk_sa1", 1'b1, 1'b1, 66, 64, 0, 1, 5, 2, 8'hAA, 8'h55);

        // Abort at cycle 40 of a faulty March run: one error is already logged by then.
        fault = 1'b1; mode = 1'b0; bist_en = 1'b1;
        @(posedge wclk);
        repeat (40) @(posedge wclk);
        @(negedge wclk);
        chk("abort_pre_err_cnt", int'(err_cnt), 1);
        chk("abort_pre_fail_addr", int'(fail_addr), 5);
        bist_en = 1'b0;
        @(negedge wclk);
        check_zero("abort");
        en_seen = 0;
        repeat (5) begin
            @(negedge wclk);
            en_seen += int'(mem_wen) + int'(mem_ren);
        end
        chk("abort_no_enables", en_seen, 0);
        full_run("restart", 1'b0, 1'b0, 162, 160, 1, 0, 0, 5, 8'h00, 8'hFF);

        // Reset at cycle 70 of a faulty March run, then a fresh run with BIST_EN still high.
        x = '{"after_rst", 162, 160, 0, 3, 5, 5, 8'h00, 8'hFF};
        sb.push_back(x);
        fault = 1'b1; mode = 1'b0; bist_en = 1'b1;
        @(posedge wclk);
        repeat (70) @(posedge wclk);
        #1;
        chk("pre_rst_err_cnt", int'(err_cnt), 1);
        #1 rst = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge wclk);
        rst = 1'b1;
        wait_done("after_rst");
        finish_run("after_rst", 0, 3);

        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_march_bist.md
# mem_march_bist

Parametrised built-in self-test engine for the dual-port FIFO memory. It runs a selectable March C- or checkerboard algorithm on the memory's write and read ports from a single clock, and compares every read against a pipelined expected word. It reports pass/fail, first failing address and a saturating error count. It sits between the FIFO pointer logic and the memory macro; the integrating mux hands it the ports while BUSY is high.

## Interface
- DATA_WIDTH, 8, memory word width
- ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH (derived localparam)
- ERR_WIDTH, 8, width of saturating error counter

- WCLK  in  1  single clock; the engine clocks both memory ports from it
- RST  in  1  asynchronous, active-low reset
- BIST_EN  in  1  level; start request in IDLE, hold high for the whole run
- MODE  in  1  0 = March C-, 1 = checkerboard; sampled at start only
- MEM_WEN  out  1  memory write enable
- MEM_WADDR  out  ADDR_WIDTH  write address
- MEM_WDATA  out  DATA_WIDTH  write data
- MEM_REN  out  1  memory read enable; memory returns data 1 cycle later
- MEM_RADDR  out  ADDR_WIDTH  read address
- MEM_RDATA  in  DATA_WIDTH  read data, valid the cycle after MEM_REN
- BUSY  out  1  high in RUN and DRAIN
- DONE  out  1  test complete; PASSFAIL, FAIL_ADDR and ERR_CNT are valid
- PASSFAIL  out  1  1 = pass, 0 = fail (meaningful only with DONE)
- FAIL_ADDR  out  ADDR_WIDTH  address of the first miscompare
- ERR_CNT  out  ERR_WIDTH  miscompare count, saturates at all-ones

## Operation
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - BIST_EN sampled high moves the engine to RUN.
  - MODE is latched on that transition.
  - ERR_CNT, FAIL_ADDR and the fail flag are cleared on that transition.
- RUN issues exactly one memory operation per cycle: either MEM_WEN or MEM_REN, never both.
- March C- uses six elements, with all-zeros and all-ones backgrounds:
  - ⇕w0
  - ⇑(r0,w1)
  - ⇑(r1,w0)
  - ⇓(r0,w1)
  - ⇓(r1,w0)
  - ⇕r0
  - ⇕ elements run ascending.
  - For a (r,w) pair, the read is issued in one cycle and the write to the same address in the next.
  - Total N = 10·DEPTH operations.
- Checkerboard uses four passes, all ascending:
  - w P
  - r P
  - w ~P
  - r ~P
  - P(addr) = 0x55-pattern (alternating 01 bits) when addr[0]=0, the bitwise inverse when addr[0]=1.
  - Total N = 4·DEPTH operations.
- Address wrap:
  - Ascending runs 0..DEPTH-1; descending runs DEPTH-1..0.
  - The element/pass advances on the terminal address; there is no wrap within an element.
- Compare:
  - The expected word and the address are pipelined alongside MEM_REN.
  - On a mismatch, ERR_CNT increments (saturating) and the fail flag is set.
  - FAIL_ADDR is written only on the first mismatch.
- DRAIN: one cycle that waits for the final read's compare.
- DONE:
  - DONE=1 and BUSY=0.
  - PASSFAIL = ~fail flag.
  - Results are held until BIST_EN goes low, then the engine returns to IDLE.
  - Results stay stable in IDLE until the next start.
- Abort: BIST_EN low during RUN or DRAIN causes:
  - return to IDLE on the next edge;
  - DONE is not asserted and PASSFAIL=0;
  - memory enables drop immediately;
  - results are cleared.
- MODE changes while not in IDLE are ignored.

## Timing
- Reset (RST low, asynchronous):
  - state = IDLE;
  - all outputs 0, including PASSFAIL=0, ERR_CNT=0, FAIL_ADDR=0;
  - memory enables low.
- Reset mid-run takes effect immediately. No further memory operation occurs after RST asserts.
- Start edge k (BIST_EN high in IDLE): the first operation (w at address 0) is driven from edge k+1.
- Operation i is driven from edge k+1+i. The last operation is i = N-1.
- Read data of operation i is compared at edge k+2+i+1.
- DONE rises at edge k+N+2. Examples:
  - March C-, DEPTH=16: edge k+162.
  - Checkerboard, DEPTH=16: edge k+66.
- All outputs are registered.

## Structure
- Package bist_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - mode enum {MARCH_CM, CHECKER};
  - march-element descriptor struct (dir, has_read, read_val, has_write, write_val);
  - constant table of the six March C- elements;
  - checkerboard pattern function.
- Sub-module bist_addr_gen: ADDR_WIDTH up/down counter with load, enable and a terminal-count flag.
- The controller handles the FSM, element index, read/write phase, compare pipeline and result registers.

## Test plan
All scenarios use the defaults: DATA_WIDTH 8, ADDR_WIDTH 4.
- Fault-free memory, MODE=0, BIST_EN held high -> DONE at start+162 cycles, PASSFAIL=1, ERR_CNT=0, exactly 160 enables seen.
- Memory with bit 3 stuck-at-1 at address 5, MODE=0 -> PASSFAIL=0, FAIL_ADDR=5, ERR_CNT=3 (r0 in elements 2, 4 and 6).
- Fault-free, MODE=1 -> DONE at start+66, PASSFAIL=1; address 5 written 0xAA in pass 1 and 0x55 in pass 3.
- Same stuck-at fault, MODE=1 -> PASSFAIL=0, FAIL_ADDR=5, ERR_CNT=1.
- BIST_EN dropped at cycle 40 of a March run -> IDLE next edge, no further enables, DONE=0, PASSFAIL=0, ERR_CNT=0; a restart then completes normally.
- RST pulsed low at cycle 70 of a run -> outputs 0 immediately; with BIST_EN still high after release, a fresh run starts at address 0.
